// File: rtl/if_id_stall_ctrl_pkg.sv
// rtl/if_id_stall_ctrl_pkg.sv - shared pipeline constants and watchdog state type
package if_id_stall_ctrl_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Load opcodes, shared with the hazard unit that raises stall
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] LB = 6'b100000;
    localparam logic [5:0] LH = 6'b100001;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_STALLING,
        WD_TIMEOUT
    } wd_state_t;

endpackage

// File: rtl/if_id_stall_ctrl_sat_counter.sv
// rtl/if_id_stall_ctrl_sat_counter.sv - saturating up-counter with clear
module sat_counter #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             at_max
);

    assign at_max = (q == MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en && !at_max) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// rtl/if_id_stall_ctrl.sv - IF/ID register with load-use stall, branch flush, stall counter and watchdog
module if_id_stall_ctrl
    import if_id_stall_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_STALL  = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] IF_instruction,
    input  logic [DATA_WIDTH-1:0] IF_PCPlus4,
    output logic [DATA_WIDTH-1:0] ID_instruction,
    output logic [DATA_WIDTH-1:0] ID_PCPlus4,
    output logic                  PCWrite,
    output logic                  ID_EX_bubble,
    output logic [CNT_WIDTH-1:0]  stall_count,
    output logic                  stall_timeout
);

    localparam int                RUN_W     = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(MAX_STALL + 1);

    logic             eff;
    logic             cnt_at_max;
    logic [RUN_W-1:0] run_q;
    logic             run_at_max;
    wd_state_t        wd_state;
    wd_state_t        wd_next;

    // A flush squashes the stalled pair, so it overrides the stall everywhere
    assign eff          = stall & ~branch_taken;
    assign PCWrite      = ~stall | branch_taken;
    assign ID_EX_bubble = eff;

    always_ff @(posedge Clk) begin
        if (Rst || branch_taken) begin
            ID_instruction <= DATA_WIDTH'(NOP_INSTR);
            ID_PCPlus4     <= '0;
        end else if (!stall) begin
            ID_instruction <= IF_instruction;
            ID_PCPlus4     <= IF_PCPlus4;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_count (
        .clk    (Clk),
        .rst    (Rst),
        .en     (eff & ~cnt_at_max),
        .clr    (1'b0),
        .q      (stall_count),
        .at_max (cnt_at_max)
    );

    sat_counter #(.WIDTH(RUN_W), .MAX(RUN_MAX)) u_run_count (
        .clk    (Clk),
        .rst    (Rst),
        .en     (eff & ~run_at_max),
        .clr    (~eff),
        .q      (run_q),
        .at_max (run_at_max)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wd_state <= WD_IDLE;
        end else begin
            wd_state <= wd_next;
        end
    end

    // Timeout is entered on the same edge the run counter steps past the limit
    always_comb begin
        wd_next = wd_state;
        unique case (wd_state)
            WD_IDLE, WD_STALLING: begin
                if (eff && run_q >= RUN_LIMIT) begin
                    wd_next = WD_TIMEOUT;
                end else if (eff) begin
                    wd_next = WD_STALLING;
                end else begin
                    wd_next = WD_IDLE;
                end
            end
            WD_TIMEOUT: wd_next = WD_TIMEOUT;
            default:    wd_next = WD_IDLE;
        endcase
    end

    assign stall_timeout = (wd_state == WD_TIMEOUT);

endmodule
